// File: rtl/sram_oq_pkg.sv
// rtl/sram_oq_pkg.sv - shared constants for the SRAM output-queue FIFO word format
package sram_oq_pkg;

    // Sideband layout of the SRAM FIFO word (data sits above the sideband)
    localparam int SOP_BIT    = 9;
    localparam int EOP_BIT    = 8;
    localparam int CNT_LSB    = 3;
    localparam int CNT_W      = 5;
    localparam int SIDEBAND_W = 10;

    // LSB of the 8-bit destination-port field inside TUSER
    localparam int DST_POS_DEFAULT = 24;

    // Ingress packer FSM encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PASS = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    // Width of one FIFO word for a data bus of tdata_bytes bytes
    function automatic int fifo_word_w(input int tdata_bytes);
        return 8 * tdata_bytes + SIDEBAND_W;
    endfunction

endpackage

// File: rtl/axis_sram_fifo_writer_if.sv
// rtl/axis_sram_fifo_writer_if.sv - AXI4-Stream ingress bundle for the SRAM FIFO writer
interface axis_sram_fifo_writer_if #(
    parameter int TDATA_WIDTH = 24,
    parameter int TUSER_WIDTH = 128
);
    logic [8*TDATA_WIDTH-1:0] tdata;
    logic [TDATA_WIDTH-1:0]   tkeep;
    logic [TUSER_WIDTH-1:0]   tuser;
    logic                     tvalid;
    logic                     tlast;
    logic                     tready;

    modport master (
        output tdata, tkeep, tuser, tvalid, tlast,
        input  tready
    );

    modport slave (
        input  tdata, tkeep, tuser, tvalid, tlast,
        output tready
    );
endinterface

// File: rtl/sram_oq_out_reg.sv
// rtl/sram_oq_out_reg.sv - one-entry registered output stage with valid/full handshake
module sram_oq_out_reg #(
    parameter int WIDTH = 202
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_word,
    input  logic             full,
    output logic             valid,
    output logic [WIDTH-1:0] word,
    output logic             wr_en
);

    assign wr_en = valid & ~full;

    // Load wins over drain so a same-cycle write-and-load keeps valid high;
    // the word itself only changes on a load, so it is stable while full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            word  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            word  <= load_word;
        end else if (wr_en) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/axis_sram_fifo_writer.sv
// rtl/axis_sram_fifo_writer.sv - packs AXI4-Stream beats into SRAM FIFO words and tracks the oq bitmap
module axis_sram_fifo_writer
    import sram_oq_pkg::*;
#(
    parameter int TDATA_WIDTH = 24,
    parameter int TUSER_WIDTH = 128,
    parameter int NUM_QUEUES  = 5,
    parameter int DST_POS     = DST_POS_DEFAULT
) (
    input  logic                                  memclk,
    input  logic                                  reset_n,
    axis_sram_fifo_writer_if.slave                s_axis,
    output logic [fifo_word_w(TDATA_WIDTH)-1:0]   fifo_din,
    output logic                                  fifo_wr_en,
    input  logic                                  fifo_full,
    output logic [NUM_QUEUES-1:0]                 oq,
    output logic [31:0]                           pkt_count,
    output logic [31:0]                           drop_count
);

    localparam int WORD_W = fifo_word_w(TDATA_WIDTH);

    logic [1:0]            state;
    logic [NUM_QUEUES-1:0] oq_next;
    logic                  out_valid;
    logic                  accept;
    logic                  load;
    logic [WORD_W-1:0]     load_word;
    logic                  unused_tuser;

    function automatic logic [CNT_W-1:0] keep_count(input logic [TDATA_WIDTH-1:0] keep);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < TDATA_WIDTH; i++) begin
            n = n + CNT_W'(keep[i]);
        end
        return n;
    endfunction

    // Even destination bits map one-to-one onto queues 0..3; all odd bits share queue 4
    assign oq_next[0] = s_axis.tuser[DST_POS];
    assign oq_next[1] = s_axis.tuser[DST_POS+2];
    assign oq_next[2] = s_axis.tuser[DST_POS+4];
    assign oq_next[3] = s_axis.tuser[DST_POS+6];
    assign oq_next[4] = s_axis.tuser[DST_POS+1] | s_axis.tuser[DST_POS+3] |
                        s_axis.tuser[DST_POS+5] | s_axis.tuser[DST_POS+7];
    assign unused_tuser = ^s_axis.tuser[TUSER_WIDTH-1:0];

    // DROP never loads the output stage, so it may keep draining beats under backpressure
    assign s_axis.tready = ~out_valid | ~fifo_full | (state == ST_DROP);
    assign accept        = s_axis.tvalid & s_axis.tready;
    assign load          = accept & ((state == ST_PASS) ||
                                     ((state == ST_IDLE) && (oq_next != '0)));

    // Assemble the FIFO word for the beat currently presented
    always_comb begin
        load_word                      = '0;
        load_word[WORD_W-1:SIDEBAND_W] = s_axis.tdata;
        load_word[SOP_BIT]             = (state == ST_IDLE);
        load_word[EOP_BIT]             = s_axis.tlast;
        load_word[CNT_LSB +: CNT_W]    = s_axis.tlast ? keep_count(s_axis.tkeep)
                                                      : CNT_W'(TDATA_WIDTH);
    end

    // Packet FSM plus oq/counter bookkeeping, all advanced on accepted beats only
    always_ff @(posedge memclk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            oq         <= '0;
            pkt_count  <= '0;
            drop_count <= '0;
        end else if (accept) begin
            case (state)
                ST_IDLE: begin
                    if (oq_next != '0) begin
                        oq <= oq_next;
                        if (s_axis.tlast) pkt_count <= pkt_count + 32'd1;
                        else              state     <= ST_PASS;
                    end else begin
                        if (s_axis.tlast) drop_count <= drop_count + 32'd1;
                        else              state      <= ST_DROP;
                    end
                end
                ST_PASS: begin
                    if (s_axis.tlast) begin
                        pkt_count <= pkt_count + 32'd1;
                        state     <= ST_IDLE;
                    end
                end
                ST_DROP: begin
                    if (s_axis.tlast) begin
                        drop_count <= drop_count + 32'd1;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    sram_oq_out_reg #(
        .WIDTH (WORD_W)
    ) u_out_reg (
        .clk       (memclk),
        .rst_n     (reset_n),
        .load      (load),
        .load_word (load_word),
        .full      (fifo_full),
        .valid     (out_valid),
        .word      (fifo_din),
        .wr_en     (fifo_wr_en)
    );

endmodule

// File: tb/tb_axis_sram_fifo_writer.sv
// tb/tb_axis_sram_fifo_writer.sv - directed table-driven bench for axis_sram_fifo_writer
module tb_axis_sram_fifo_writer;

    localparam int W = 8 * 24 + 10;

    logic          memclk;
    logic          reset_n;
    logic [W-1:0]  fifo_din;
    logic          fifo_wr_en;
    logic          fifo_full;
    logic [4:0]    oq;
    logic [31:0]   pkt_count;
    logic [31:0]   drop_count;

    axis_sram_fifo_writer_if #(.TDATA_WIDTH(24), .TUSER_WIDTH(128)) s_if ();

    axis_sram_fifo_writer #(
        .TDATA_WIDTH (24),
        .TUSER_WIDTH (128),
        .NUM_QUEUES  (5),
        .DST_POS     (24)
    ) dut (
        .memclk     (memclk),
        .reset_n    (reset_n),
        .s_axis     (s_if),
        .fifo_din   (fifo_din),
        .fifo_wr_en (fifo_wr_en),
        .fifo_full  (fifo_full),
        .oq         (oq),
        .pkt_count  (pkt_count),
        .drop_count (drop_count)
    );

    initial memclk = 1'b0;
    always #5 memclk = ~memclk;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    logic [W-1:0] got_q[$];
    int           got_cyc[$];

    always @(posedge memclk) cyc <= cyc + 1;

    always @(negedge memclk) begin
        if (fifo_wr_en === 1'b1) begin
            got_q.push_back(fifo_din);
            got_cyc.push_back(cyc);
        end
    end

    typedef struct {
        logic [31:0] tag;
        logic [23:0] keep;
        logic [7:0]  dst;
        bit          last;
        bit          wr;
        bit          sop;
        bit          eop;
        logic [4:0]  cnt;
        logic [4:0]  oq;
        int          pkt;
        int          drop;
    } vec_t;

    vec_t tbl[12];

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [W-1:0] mk_word(input logic [31:0] tag, input bit sop,
                                            input bit eop, input logic [4:0] cnt);
        return {{6{tag}}, sop, eop, cnt, 3'b000};
    endfunction

    task automatic drive(input logic [31:0] tag, input logic [23:0] keep,
                         input logic [7:0] dst, input bit last);
        s_if.tdata  = {6{tag}};
        s_if.tkeep  = keep;
        s_if.tuser  = {96'h0, dst, 24'hFFFFFF};
        s_if.tlast  = last;
        s_if.tvalid = 1'b1;
    endtask

    task automatic send_beat(input logic [31:0] tag, input logic [23:0] keep,
                             input logic [7:0] dst, input bit last);
        int n;
        n = 0;
        drive(tag, keep, dst, last);
        forever begin
            @(negedge memclk);
            if (s_if.tready === 1'b1) break;
            n++;
            if (n > 50) begin
                check("tready_timeout", 256'(s_if.tready), 256'(1));
                break;
            end
        end
        @(posedge memclk);
        #1;
        s_if.tvalid = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{32'hA0A0A000, 24'hFFFFFF, 8'h04, 1'b0, 1'b1, 1'b1, 1'b0, 5'd24, 5'b00010, 0, 0};
        tbl[1]  = '{32'hA1A1A101, 24'hFFFFFF, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 5'd24, 5'b00010, 0, 0};
        tbl[2]  = '{32'hA2A2A202, 24'h00FFFF, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b1, 5'd16, 5'b00010, 1, 0};
        tbl[3]  = '{32'hB0B0B000, 24'h000FFF, 8'h02, 1'b1, 1'b1, 1'b1, 1'b1, 5'd12, 5'b10000, 2, 0};
        tbl[4]  = '{32'hC0C0C000, 24'hFFFFFF, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  5'b10000, 2, 0};
        tbl[5]  = '{32'hC1C1C101, 24'h0000FF, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  5'b10000, 2, 1};
        tbl[6]  = '{32'hD0D0D000, 24'h0000FF, 8'h01, 1'b1, 1'b1, 1'b1, 1'b1, 5'd8,  5'b00001, 3, 1};
        tbl[7]  = '{32'hE0E0E000, 24'hFFFFFF, 8'h55, 1'b0, 1'b1, 1'b1, 1'b0, 5'd24, 5'b01111, 3, 1};
        tbl[8]  = '{32'hE1E1E101, 24'h00003F, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b1, 5'd6,  5'b01111, 4, 1};
        tbl[9]  = '{32'hF0F0F000, 24'hFFFFFF, 8'hAA, 1'b0, 1'b1, 1'b1, 1'b0, 5'd24, 5'b10000, 4, 1};
        tbl[10] = '{32'hF1F1F101, 24'hFFFFFF, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 5'd24, 5'b10000, 5, 1};
        tbl[11] = '{32'h90909000, 24'hFFFFFF, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  5'b10000, 5, 2};

        reset_n     = 1'b0;
        fifo_full   = 1'b0;
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        s_if.tdata  = '0;
        s_if.tkeep  = '0;
        s_if.tuser  = '0;
        repeat (3) @(posedge memclk);
        @(negedge memclk);
        check("rst_wr_en", 256'(fifo_wr_en), 256'(0));
        check("rst_din", 256'(fifo_din), 256'(0));
        check("rst_oq", 256'(oq), 256'(0));
        check("rst_pkt", 256'(pkt_count), 256'(0));
        check("rst_drop", 256'(drop_count), 256'(0));
        check("rst_tready", 256'(s_if.tready), 256'(1));
        @(posedge memclk);
        #1 reset_n = 1'b1;
        @(posedge memclk);
        #1;

        // Table: three-beat, single-beat, dropped then passed, back-to-back packets
        for (int i = 0; i < 12; i++) begin
            send_beat(tbl[i].tag, tbl[i].keep, tbl[i].dst, tbl[i].last);
            check($sformatf("tbl%0d_oq", i), 256'(oq), 256'(tbl[i].oq));
            check($sformatf("tbl%0d_pkt", i), 256'(pkt_count), 256'(tbl[i].pkt));
            check($sformatf("tbl%0d_drop", i), 256'(drop_count), 256'(tbl[i].drop));
        end
        repeat (3) @(posedge memclk);
        #1;
        begin
            int k;
            k = 0;
            check("tbl_nwords", 256'(got_q.size()), 256'(9));
            for (int i = 0; i < 12; i++) begin
                if (tbl[i].wr) begin
                    if (k < got_q.size())
                        check($sformatf("tbl%0d_word", i), 256'(got_q[k]),
                              256'(mk_word(tbl[i].tag, tbl[i].sop, tbl[i].eop, tbl[i].cnt)));
                    k++;
                end
            end
            if (got_q.size() == 9)
                check("b2b_consecutive", 256'(got_cyc[8] - got_cyc[5]), 256'(3));
        end

        // Stall: fifo_full high for 5 cycles while beat K1 waits
        got_q.delete();
        got_cyc.delete();
        send_beat(32'h11110000, 24'hFFFFFF, 8'h04, 1'b0);
        fifo_full = 1'b1;
        drive(32'h11110001, 24'hFFFFFF, 8'hFF, 1'b0);
        for (int c = 0; c < 5; c++) begin
            @(negedge memclk);
            check($sformatf("stall%0d_tready", c), 256'(s_if.tready), 256'(0));
            check($sformatf("stall%0d_din", c), 256'(fifo_din),
                  256'(mk_word(32'h11110000, 1'b1, 1'b0, 5'd24)));
            check($sformatf("stall%0d_wr_en", c), 256'(fifo_wr_en), 256'(0));
            @(posedge memclk);
            #1;
        end
        fifo_full = 1'b0;
        send_beat(32'h11110001, 24'hFFFFFF, 8'hFF, 1'b0);
        send_beat(32'h11110002, 24'hFFFFFF, 8'hFF, 1'b0);
        send_beat(32'h11110003, 24'h0007FF, 8'hFF, 1'b1);
        repeat (3) @(posedge memclk);
        #1;
        check("stall_nwords", 256'(got_q.size()), 256'(4));
        if (got_q.size() == 4) begin
            check("stall_w0", 256'(got_q[0]), 256'(mk_word(32'h11110000, 1'b1, 1'b0, 5'd24)));
            check("stall_w1", 256'(got_q[1]), 256'(mk_word(32'h11110001, 1'b0, 1'b0, 5'd24)));
            check("stall_w2", 256'(got_q[2]), 256'(mk_word(32'h11110002, 1'b0, 1'b0, 5'd24)));
            check("stall_w3", 256'(got_q[3]), 256'(mk_word(32'h11110003, 1'b0, 1'b1, 5'd11)));
        end
        check("stall_pkt", 256'(pkt_count), 256'(6));

        // Reset in the middle of a packet, then a fresh two-beat packet
        send_beat(32'h22220000, 24'hFFFFFF, 8'h04, 1'b0);
        send_beat(32'h22220001, 24'hFFFFFF, 8'hFF, 1'b0);
        reset_n = 1'b0;
        @(negedge memclk);
        check("mid_rst_wr_en", 256'(fifo_wr_en), 256'(0));
        check("mid_rst_din", 256'(fifo_din), 256'(0));
        check("mid_rst_oq", 256'(oq), 256'(0));
        check("mid_rst_pkt", 256'(pkt_count), 256'(0));
        check("mid_rst_drop", 256'(drop_count), 256'(0));
        check("mid_rst_tready", 256'(s_if.tready), 256'(1));
        repeat (2) @(posedge memclk);
        #1 reset_n = 1'b1;
        got_q.delete();
        got_cyc.delete();
        send_beat(32'h33330000, 24'hFFFFFF, 8'h01, 1'b0);
        send_beat(32'h33330001, 24'h0000FF, 8'hFF, 1'b1);
        repeat (3) @(posedge memclk);
        #1;
        check("post_rst_oq", 256'(oq), 256'(5'b00001));
        check("post_rst_pkt", 256'(pkt_count), 256'(1));
        check("post_rst_drop", 256'(drop_count), 256'(0));
        check("post_rst_nwords", 256'(got_q.size()), 256'(2));
        if (got_q.size() == 2) begin
            check("post_rst_w0", 256'(got_q[0]), 256'(mk_word(32'h33330000, 1'b1, 1'b0, 5'd24)));
            check("post_rst_w1", 256'(got_q[1]), 256'(mk_word(32'h33330001, 1'b0, 1'b1, 5'd8)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
